// File: rtl/tlp_xcvr_pkg.sv
// tlp_xcvr_pkg: types and helpers shared by the TLP transceiver (tlp_recv, tlp_send).
//   Action      : decoded register action, a type tag plus an overlay of RegRead /
//                 RegWrite / RegError payloads (all overlays are the same width).
//   CHAN_NBITS  : channel field width; the DW index comes from address bits [CHAN_NBITS+1:2].
//   hdr_*()     : field extraction from the first header QW (DW0 in [31:0], DW1 in [63:32]).
package tlp_xcvr_pkg;

  localparam int CHAN_NBITS = 4;

  typedef logic [63:0]           uint64;
  typedef logic [15:0]           BusID;
  typedef logic [7:0]            Tag;
  typedef logic [CHAN_NBITS-1:0] Channel;
  typedef logic [31:0]           Data;

  typedef enum logic [1:0] {
    ACT_READ  = 2'd0,
    ACT_WRITE = 2'd1,
    ACT_ERROR = 2'd2
  } ActionType;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_FMT  = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_SOP  = 2'd3
  } ErrorCode;

  typedef struct packed {
    logic [7:0] pad;
    BusID       reqID;
    Tag         tag;
    Channel     chan;
  } RegRead;

  typedef struct packed {
    Channel chan;
    Data    data;
  } RegWrite;

  typedef struct packed {
    logic [CHAN_NBITS+29:0] pad;
    ErrorCode               code;
  } RegError;

  typedef union packed {
    RegRead  rd;
    RegWrite wr;
    RegError err;
  } ActionBody;

  typedef struct packed {
    ActionType typ;
    ActionBody body;
  } Action;

  // 3DW memory request fmt/type codes
  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;

  function automatic logic [2:0] hdr_fmt(uint64 qw0);
    return qw0[31:29];
  endfunction

  function automatic logic [4:0] hdr_type(uint64 qw0);
    return qw0[28:24];
  endfunction

  function automatic logic [9:0] hdr_len(uint64 qw0);
    return qw0[9:0];
  endfunction

  function automatic BusID hdr_req_id(uint64 qw0);
    return qw0[63:48];
  endfunction

  function automatic Tag hdr_tag(uint64 qw0);
    return qw0[47:40];
  endfunction

endpackage

// File: rtl/tlp_hdr_decode.sv
// tlp_hdr_decode: combinational header decode for the receive path.
//   hdr      in  latched first header QW (DW0/DW1)
//   qw1      in  second header QW; [31:0] is the address, [63:32] is write data
//                when the address is DW-odd
//   is_read  out well-formed single-DW MRd32
//   is_write out well-formed single-DW MWr32
//   err      out ERR_FMT for unsupported fmt/type, ERR_LEN for length != 1
//   req_id, tag, chan, addr2, wdata out  extracted fields
module tlp_hdr_decode #(
  parameter int CHAN_NBITS = tlp_xcvr_pkg::CHAN_NBITS
) (
  input  tlp_xcvr_pkg::uint64    hdr,
  input  tlp_xcvr_pkg::uint64    qw1,
  output logic                   is_read,
  output logic                   is_write,
  output tlp_xcvr_pkg::ErrorCode err,
  output tlp_xcvr_pkg::BusID     req_id,
  output tlp_xcvr_pkg::Tag       tag,
  output tlp_xcvr_pkg::Channel   chan,
  output logic                   addr2,
  output tlp_xcvr_pkg::Data      wdata
);
  import tlp_xcvr_pkg::*;

  logic [2:0] fmt;
  logic [4:0] typ;
  logic [9:0] len;
  logic       fmt_rd;
  logic       fmt_wr;

  assign fmt    = hdr_fmt(hdr);
  assign typ    = hdr_type(hdr);
  assign len    = hdr_len(hdr);
  assign fmt_rd = (fmt == FMT_3DW_NODATA) && (typ == TYPE_MEM);
  assign fmt_wr = (fmt == FMT_3DW_DATA) && (typ == TYPE_MEM);

  // Unsupported fmt/type takes precedence over a bad length.
  always_comb begin
    err = ERR_NONE;
    if (!(fmt_rd || fmt_wr)) err = ERR_FMT;
    else if (len != 10'd1)   err = ERR_LEN;
  end

  assign is_read  = fmt_rd && (err == ERR_NONE);
  assign is_write = fmt_wr && (err == ERR_NONE);
  assign req_id   = hdr_req_id(hdr);
  assign tag      = hdr_tag(hdr);
  assign chan     = Channel'(qw1[CHAN_NBITS+1:2]);
  assign addr2    = qw1[2];
  assign wdata    = qw1[63:32];

  // Upper address bits and the byte offset do not select anything here.
  logic unused_addr;
  assign unused_addr = ^{qw1[31:CHAN_NBITS+2], qw1[1:0]};

endmodule

// File: rtl/tlp_recv.sv
// tlp_recv: decodes inbound 64-bit SOP/EOP-framed PCIe TLPs into single-entry
// register actions (reads, writes, errors). Only 3DW single-DW MRd32/MWr32 are
// decoded; anything else is drained.
//   pcieClk_in   in   core clock
//   pcieRstN_in  in   asynchronous active-low reset
//   rxData_in    in   RX QW (DW0 in [31:0], DW1 in [63:32])
//   rxValid_in   in   RX QW valid
//   rxReady_out  out  RX QW accept; low while an action is pending and during reset
//   rxSOP_in     in   first QW of TLP
//   rxEOP_in     in   last QW of TLP
//   actData_out  out  decoded action
//   actValid_out out  action valid; held with stable data until actReady_in
//   actReady_in  in   action consumed
// Build option: TLP_RECV_STRICT_EN emits ACT_ERROR (ERR_FMT/ERR_LEN/ERR_SOP) for
// malformed or unsupported TLPs; without it such TLPs are drained silently.
module tlp_recv #(
  parameter int CHAN_NBITS = tlp_xcvr_pkg::CHAN_NBITS
) (
  input  logic                pcieClk_in,
  input  logic                pcieRstN_in,
  input  tlp_xcvr_pkg::uint64 rxData_in,
  input  logic                rxValid_in,
  output logic                rxReady_out,
  input  logic                rxSOP_in,
  input  logic                rxEOP_in,
  output tlp_xcvr_pkg::Action actData_out,
  output logic                actValid_out,
  input  logic                actReady_in
);
  import tlp_xcvr_pkg::*;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR1  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0] state, nxt_state;
  logic       rdy_en;
  uint64      hdr_q;
  Channel     chan_q;
  logic       rx_fire;
  logic       load_act, latch_hdr, latch_chan;
  Action      nxt_act;
  logic       err_req;
  ErrorCode   err_code;

  logic       dec_rd, dec_wr, dec_addr2;
  ErrorCode   dec_err;
  BusID       dec_req_id;
  Tag         dec_tag;
  Channel     dec_chan;
  Data        dec_wdata;

  tlp_hdr_decode #(.CHAN_NBITS(CHAN_NBITS)) u_dec (
    .hdr      (hdr_q),
    .qw1      (rxData_in),
    .is_read  (dec_rd),
    .is_write (dec_wr),
    .err      (dec_err),
    .req_id   (dec_req_id),
    .tag      (dec_tag),
    .chan     (dec_chan),
    .addr2    (dec_addr2),
    .wdata    (dec_wdata)
  );

  function automatic Action read_act(BusID r, Tag t, Channel c);
    Action a = '0;
    a.typ           = ACT_READ;
    a.body.rd.reqID = r;
    a.body.rd.tag   = t;
    a.body.rd.chan  = c;
    return a;
  endfunction

  function automatic Action write_act(Channel c, Data d);
    Action a = '0;
    a.typ          = ACT_WRITE;
    a.body.wr.chan = c;
    a.body.wr.data = d;
    return a;
  endfunction

`ifdef TLP_RECV_STRICT_EN
  function automatic Action error_act(ErrorCode e);
    Action a = '0;
    a.typ           = ACT_ERROR;
    a.body.err.code = e;
    return a;
  endfunction
`else
  logic unused_err;
  assign unused_err = err_req ^ (^err_code);
`endif

  // A pending action blocks the RX stream, so a load never overwrites one.
  assign rxReady_out = rdy_en && !actValid_out;
  assign rx_fire     = rxValid_in && rxReady_out;

  always_comb begin
    nxt_state  = state;
    load_act   = 1'b0;
    nxt_act    = '0;
    latch_hdr  = 1'b0;
    latch_chan = 1'b0;
    err_req    = 1'b0;
    err_code   = ERR_NONE;
    if (rx_fire) begin
      if (rxSOP_in) begin
        // SOP always restarts decode, abandoning any TLP in progress.
        latch_hdr = 1'b1;
        nxt_state = rxEOP_in ? S_IDLE : S_HDR1;
        if (state != S_IDLE) begin
          err_req  = 1'b1;
          err_code = ERR_SOP;
        end else if (rxEOP_in) begin
          err_req  = 1'b1;
          err_code = ERR_LEN;
        end
      end else begin
        case (state)
          S_IDLE: begin
            err_req  = 1'b1;
            err_code = ERR_SOP;
          end
          S_HDR1: begin
            latch_chan = 1'b1;
            nxt_state  = rxEOP_in ? S_IDLE : S_DRAIN;
            if (dec_err != ERR_NONE) begin
              err_req  = 1'b1;
              err_code = dec_err;
            end else if (dec_rd) begin
              load_act = 1'b1;
              nxt_act  = read_act(dec_req_id, dec_tag, dec_chan);
            end else if (dec_wr) begin
              if (dec_addr2) begin
                load_act = 1'b1;
                nxt_act  = write_act(dec_chan, dec_wdata);
              end else if (rxEOP_in) begin
                // Aligned write ended before its data QW.
                err_req  = 1'b1;
                err_code = ERR_LEN;
              end else begin
                nxt_state = S_DATA;
              end
            end
          end
          S_DATA: begin
            load_act  = 1'b1;
            nxt_act   = write_act(chan_q, rxData_in[31:0]);
            nxt_state = rxEOP_in ? S_IDLE : S_DRAIN;
          end
          default: begin
            if (rxEOP_in) nxt_state = S_IDLE;
          end
        endcase
      end
    end
`ifdef TLP_RECV_STRICT_EN
    if (err_req) begin
      load_act = 1'b1;
      nxt_act  = error_act(err_code);
    end
`endif
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      state        <= S_IDLE;
      rdy_en       <= 1'b0;
      actValid_out <= 1'b0;
    end else begin
      state  <= nxt_state;
      rdy_en <= 1'b1;
      if (load_act)         actValid_out <= 1'b1;
      else if (actReady_in) actValid_out <= 1'b0;
    end
  end

  // Datapath registers carry no reset; they are qualified by state/actValid_out.
  always_ff @(posedge pcieClk_in) begin
    if (latch_hdr)  hdr_q       <= rxData_in;
    if (latch_chan) chan_q      <= dec_chan;
    if (load_act)   actData_out <= nxt_act;
  end

endmodule

// File: doc/tlp_recv.md
# tlp_recv

Decodes inbound PCIe TLPs from the hard-IP receive stream (64-bit, SOP/EOP framed) into single-entry register actions: reads, writes and receive errors. Sits between the PCIe core's RX port and the action pipe consumed by tlp_send, and is the receive half of the TLP transceiver. Handles 3DW-header single-DW memory reads and writes only; everything else is drained.

## Interface
- CHAN_NBITS, default from tlp_xcvr_pkg: width of the channel field (DW index taken from address bits [CHAN_NBITS+1:2]).
- pcieClk_in  in  1  125MHz core clock from PCIe PLL.
- pcieRstN_in  in  1  Reset; asynchronous, active-low.
- rxData_in  in  64  RX QW (tlp_xcvr_pkg::uint64); DW0 in [31:0], DW1 in [63:32].
- rxValid_in  in  1  RX QW valid.
- rxReady_out  out  1  RX QW accept.
- rxSOP_in  in  1  First QW of TLP.
- rxEOP_in  in  1  Last QW of TLP.
- actData_out  out  Action  Decoded action (typ, RegRead/RegWrite/ErrorCode overlay).
- actValid_out  out  1  Action valid.
- actReady_in  in  1  Action consumed.

## Operation
- QW transfer when rxValid_in && rxReady_out. rxReady_out = !actValid_out; held 0 while pcieRstN_in low.
- Header: fmt = DW0[31:29], type = DW0[28:24], length = DW0[9:0]; reqID = DW1[31:16], tag = DW1[15:8]; address = DW2 (QW1[31:0]).
- MRd32: fmt 000, type 00000. MWr32: fmt 010, type 00000. Any other fmt/type -> ERR_FMT. length != 1 -> ERR_LEN.
- Write data position: addr[2]=1 -> QW1[63:32] (2-QW TLP); addr[2]=0 -> QW2[31:0] (3-QW TLP, QW1[63:32] is a gap).
- States:
  - S_IDLE: accept QW with SOP -> latch header fields, go S_HDR1. QW without SOP -> discard (ERR_SOP when strict), stay.
  - S_HDR1: accept QW1. Read -> load ACT_READ {reqID, tag, chan}, go S_DRAIN if !EOP else S_IDLE. Write with addr[2]=1 -> load ACT_WRITE {chan, data=QW1[63:32]}. Write with addr[2]=0 -> S_DATA. Error -> S_DRAIN.
  - S_DATA: accept QW2 -> load ACT_WRITE {chan, data=QW2[31:0]}; S_IDLE if EOP else S_DRAIN.
  - S_DRAIN: discard QWs until EOP accepted -> S_IDLE.
- Loading an action sets actValid_out; it holds with data stable until actReady_in, then clears.
- Boundary: SOP seen in S_HDR1/S_DATA/S_DRAIN -> abandon current TLP (ERR_SOP when strict, no action otherwise), treat QW as new QW0. EOP on QW0 or on QW1 of an aligned write -> ERR_LEN, S_IDLE. Action loads only when actValid_out is clear (guaranteed by rxReady_out gating).
- Reset (any time): state S_IDLE, actValid_out 0, actData_out 'X, rxReady_out 0 during reset, 1 one cycle after deassertion.

## Timing
- actValid_out rises on the cycle after the QW that completes decode: 2 cycles after SOP QW for reads and odd-DW writes, 3 for aligned writes.
- Max throughput: one action every (TLP QWs + 1) cycles with actReady_in held high; one bubble per action from rxReady_out gating.
- actReady_in and actValid_out high together -> action retired that edge; rxReady_out high next cycle.

## Configuration
- TLP_RECV_STRICT_EN defined: malformed/unsupported TLPs emit ACT_ERROR with ErrorCode (ERR_FMT, ERR_LEN, ERR_SOP), loaded on the cycle the error is detected; remainder drained.
- Not defined: same TLPs drained silently; no ACT_ERROR ever emitted; ErrorCode logic removed.

## Structure
- tlp_xcvr_pkg: Action, ActionType (ACT_READ/ACT_WRITE/ACT_ERROR), RegRead, RegWrite, ErrorCode, BusID, Tag, Channel, Data, uint64, CHAN_NBITS, fmt/type constants, header field extraction functions.
- One sub-module is natural: tlp_hdr_decode (combinational QW0/QW1 field extraction and classification into read/write/error-code).

## Test plan
- MWr32 DW0 len 1, addr 0x00000014, QW1[63:32]=0xCAFEBABE, 2 QWs -> ACT_WRITE chan 5 data 0xCAFEBABE, 2 cycles after SOP.
- MWr32 addr 0x00000010, QW2[31:0]=0x12345678, 3 QWs -> ACT_WRITE chan 4 data 0x12345678.
- MRd32 reqID 0x0100 tag 0x07 addr 0x00000008 -> ACT_READ chan 2 reqID 0x0100 tag 0x07.
- actReady_in low 5 cycles with second TLP pending -> actValid_out/actData_out stable, rxReady_out 0, second TLP decoded intact after release.
- MWr32 length 2 -> strict: ACT_ERROR ERR_LEN then drain to EOP; non-strict: no action, next TLP decoded normally.
- pcieRstN_in pulsed low after QW0 of a write -> actValid_out 0, following MRd32 decoded correctly.
